register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 90 +++++++++
 1 files changed

// File: rtl/register_file.sv
// Renamed architectural register file: each register holds a committed value and
// the ROB tag of its pending producer, with combinational operand lookup and commit bypass.
module register_file #(
  parameter int REG_NUM  = 32,
  parameter int ROB_ID_W = 5,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic [4:0]          rs1_from_cmd,
  input  logic [4:0]          rs2_from_cmd,
  output logic [DATA_W-1:0]   V1_to_cmd,
  output logic [DATA_W-1:0]   V2_to_cmd,
  output logic [ROB_ID_W-1:0] Q1_to_cmd,
  output logic [ROB_ID_W-1:0] Q2_to_cmd,
  input  logic                enable_sign_from_cmd,
  input  logic [4:0]          rd_from_cmd,
  input  logic [ROB_ID_W-1:0] rob_id_from_cmd,
  input  logic                commit_sign,
  input  logic [4:0]          rd_from_rob,
  input  logic [ROB_ID_W-1:0] Q_from_rob,
  input  logic [DATA_W-1:0]   V_from_rob,
  input  logic                rollback_sign
);

  localparam int IDX_W = 5;
  localparam logic [ROB_ID_W-1:0] INVALID_ROB = '0;

  logic [DATA_W-1:0]   value [REG_NUM];
  logic [ROB_ID_W-1:0] tag   [REG_NUM];

  logic issue_ok;
  logic commit_ok;

  assign issue_ok  = enable_sign_from_cmd && !rollback_sign && (rd_from_cmd != '0);
  assign commit_ok = commit_sign && (rd_from_rob != '0);

  // Operand lookup sees pre-edge state; a commit retiring the current producer is forwarded.
  function automatic logic [DATA_W+ROB_ID_W-1:0] lookup(input logic [IDX_W-1:0] rs);
    logic [DATA_W-1:0]   v;
    logic [ROB_ID_W-1:0] q;
    v = '0;
    q = INVALID_ROB;
    if (rs == '0) begin
      v = '0;
      q = INVALID_ROB;
    end else if (commit_sign && (rd_from_rob == rs) && (Q_from_rob == tag[rs])) begin
      v = V_from_rob;
      q = INVALID_ROB;
    end else if (tag[rs] == INVALID_ROB) begin
      v = value[rs];
      q = INVALID_ROB;
    end else begin
      v = '0;
      q = tag[rs];
    end
    return {v, q};
  endfunction

  always_comb begin
    {V1_to_cmd, Q1_to_cmd} = lookup(rs1_from_cmd);
    {V2_to_cmd, Q2_to_cmd} = lookup(rs2_from_cmd);
  end

  // State update: x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value[i] <= '0;
        tag[i]   <= INVALID_ROB;
      end
    end else if (rdy) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (commit_ok && (rd_from_rob == IDX_W'(i))) begin
          value[i] <= V_from_rob;
        end
        // Rollback clears all; a new rename beats the commit clear of an older tag.
        if (rollback_sign) begin
          tag[i] <= INVALID_ROB;
        end else if (issue_ok && (rd_from_cmd == IDX_W'(i))) begin
          tag[i] <= rob_id_from_cmd;
        end else if (commit_ok && (rd_from_rob == IDX_W'(i)) && (tag[i] == Q_from_rob)) begin
          tag[i] <= INVALID_ROB;
        end
      end
    end
  end

endmodule
